stream_protocol_checker: RTL and testbench
==========================================

Name: stream_protocol_checker

Overview:
- Parametrised, synthesizable protocol checker and transfer counter for NUM_CH independent valid/ready streams.
- Generalises the single-signal driver/monitor sampling used in our benches to multi-channel, multi-bit handshaked streams.
- Adds stall tracking, sticky violation flags, per-channel transfer counts and an interrupt.
- Sits passively alongside a DUT stream port (bench or on-chip debug); it drives nothing on the observed bus.

Parameters:
- NUM_CH, 4: number of independent streams observed (1..16).
- DATA_W, 8: data width per channel (1..64).
- CNT_W, 16: width of each per-channel transfer counter.
- STALL_MAX, 64: consecutive stall cycles that raise a timeout (2..2^16-1).

Ports:
- clk  input  1  single clock; all sampling on posedge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  checking/counting enable; when 0, all internal state holds.
- clear  input  1  synchronous clear of counters, stall state and error flags.
- valid  input  NUM_CH  per-channel valid.
- ready  input  NUM_CH  per-channel ready.
- data  input  NUM_CH*DATA_W  per-channel data; channel c occupies bits [c*DATA_W +: DATA_W].
- err_mask  input  3  irq enable for {timeout, drop, stable}, bits [2:0].
- xfer_count  output  NUM_CH*CNT_W  per-channel handshake count; channel c occupies bits [c*CNT_W +: CNT_W].
- err_stable  output  NUM_CH  sticky: data changed while stalled.
- err_drop  output  NUM_CH  sticky: valid withdrawn before handshake.
- err_timeout  output  NUM_CH  sticky: stall reached STALL_MAX.
- irq  output  1  OR over channels of the enabled error flags.

Behaviour:
- Reset (reset=0, async): all xfer_count, err_*, stall counters and pending bits = 0; irq = 0. Release is synchronous to the next posedge.
- Per channel c, evaluated at each posedge with en=1 and clear=0:
  - handshake = valid[c] & ready[c]; stall = valid[c] & ~ready[c].
  - pending[c] <= stall. held_data[c] <= data[c] when stall & ~pending (first stall cycle only).
  - handshake: xfer_count[c] increments by 1 and wraps 2^CNT_W-1 -> 0 with no flag. stall_cnt[c] <= 0.
  - stall: stall_cnt[c] <= stall_cnt[c]+1, saturating at STALL_MAX. err_timeout[c] sets on the edge where the incremented value equals STALL_MAX.
  - pending & valid & data != held_data: err_stable[c] sets. This applies on both stall and handshake cycles; the checked data is the value present on the completing edge.
  - pending & ~valid: err_drop[c] sets; stall_cnt[c] <= 0.
  - ~valid & ~pending: stall_cnt[c] <= 0.
- Flag/count latency: each flag or count update is visible one cycle after the sampling posedge (registered).
- Error flags stay set until clear or reset.
- irq: combinational OR of (err_timeout & err_mask[2]) | (err_drop & err_mask[1]) | (err_stable & err_mask[0]) over all channels. It therefore changes in the same cycle as the flags.
- clear=1 (en don't-care): zeroes xfer_count, err_*, stall_cnt and pending in one cycle. A handshake or violation on the same edge is discarded.
- en=0, clear=0: all state holds. A stall spanning an en=0 window resumes counting from the held stall_cnt. Pending/held_data are not updated, so data changes during en=0 are not flagged.
- Channels are fully independent; simultaneous events on different channels all take effect on the same edge.
- Reset asserted mid-stall: state is lost immediately. The first post-reset stall restarts at count 1 and captures fresh held_data.

Test Plan:
- Reset, en=1, ch0 5 back-to-back handshakes (valid=ready=1, data 0x10..0x14) -> xfer_count ch0 = 5, others 0, no err, irq=0.
- ch1 valid=1, ready=0 for 3 cycles with data 0xA5 steady, then ready=1 -> count ch1 = 1, no flags. Repeat with data changing to 0x5A on stall cycle 2 -> err_stable[1]=1, irq=1 with err_mask=3'b001, irq=0 with err_mask=0.
- ch2 valid=1, ready=0 for 2 cycles, then valid=0 -> err_drop[2]=1 one cycle after the drop edge; xfer_count ch2 unchanged.
- ch3 stalled with STALL_MAX=64 -> err_timeout[3]=0 after 63 stall edges and =1 after the 64th. A handshake on edge 65 -> count ch3 = 1, flag stays set.
- CNT_W=4, 17 handshakes on ch0 -> xfer_count ch0 = 1 (wrap). Then clear=1 on the same edge as a handshake -> count 0, all flags 0.
- en=0 for 10 cycles mid-stall (stall_cnt=5) with valid toggling -> no flag/count change; after en=1, timeout triggers after 59 further stall edges. Async reset pulse mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/stream_protocol_checker.sv
// Purpose : passive valid/ready protocol checker and per-channel transfer counter
//           for NUM_CH independent streams (stall timeout, drop and data-stability checks).
// Latency : every count and flag update is registered, visible one cycle after the
//           sampling posedge; irq is a combinational OR of the registered flags.
// Backpressure: none exerted; the block only observes valid/ready and drives nothing back.
//
// Ports:
//   clk          sampling clock, all state updates on posedge
//   reset        asynchronous active-low reset, synchronous release
//   en           checking/counting enable; 0 freezes all internal state
//   clear        synchronous clear of counts, stall state and flags (overrides en)
//   valid/ready  per-channel handshake signals, one bit per channel
//   data         per-channel payload, channel c at [c*DATA_W +: DATA_W]
//   err_mask     irq enables for {timeout, drop, stable}
//   xfer_count   per-channel handshake count, channel c at [c*CNT_W +: CNT_W]
//   err_stable   sticky: payload changed while the transfer was stalled
//   err_drop     sticky: valid withdrawn before the handshake completed
//   err_timeout  sticky: a single stall lasted STALL_MAX cycles
//   irq          OR over channels of the masked error flags

module stream_protocol_checker #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clear,
    input  logic [NUM_CH-1:0]          valid,
    input  logic [NUM_CH-1:0]          ready,
    input  logic [NUM_CH*DATA_W-1:0]   data,
    input  logic [2:0]                 err_mask,
    output logic [NUM_CH*CNT_W-1:0]    xfer_count,
    output logic [NUM_CH-1:0]          err_stable,
    output logic [NUM_CH-1:0]          err_drop,
    output logic [NUM_CH-1:0]          err_timeout,
    output logic                       irq
);

    // Stall counter only needs to reach STALL_MAX, where it saturates.
    localparam int                SC_W      = $clog2(STALL_MAX + 1);
    localparam logic [SC_W-1:0]   STALL_LIM = SC_W'(STALL_MAX);
    localparam logic [SC_W-1:0]   STALL_PRE = SC_W'(STALL_MAX - 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

        logic [DATA_W-1:0] ch_data;
        logic              handshake;
        logic              stall;

        // Registered per-channel state
        logic              pending_q;
        logic [DATA_W-1:0] held_q;
        logic [SC_W-1:0]   stall_cnt_q;
        logic [CNT_W-1:0]  count_q;
        logic              stable_q;
        logic              drop_q;
        logic              timeout_q;

        // Next-state values for an enabled, non-cleared edge
        logic              pending_d;
        logic [DATA_W-1:0] held_d;
        logic [SC_W-1:0]   stall_cnt_d;
        logic [CNT_W-1:0]  count_d;
        logic              stable_d;
        logic              drop_d;
        logic              timeout_d;

        assign ch_data   = data[c*DATA_W +: DATA_W];
        assign handshake = valid[c] & ready[c];
        assign stall     = valid[c] & ~ready[c];

        always_comb begin
            pending_d   = stall;
            held_d      = held_q;
            stall_cnt_d = stall_cnt_q;
            count_d     = count_q;
            stable_d    = stable_q;
            drop_d      = drop_q;
            timeout_d   = timeout_q;

            // Snapshot the payload only on the first stalled cycle so that the
            // whole stall, including the completing edge, is compared against it.
            if (stall && !pending_q) begin
                held_d = ch_data;
            end

            if (handshake) begin
                count_d     = count_q + CNT_W'(1);   // wraps silently
                stall_cnt_d = '0;
            end else if (stall) begin
                if (stall_cnt_q != STALL_LIM) begin
                    stall_cnt_d = stall_cnt_q + SC_W'(1);
                end
                // Fires on the edge whose incremented count reaches STALL_MAX.
                if (stall_cnt_q == STALL_PRE) begin
                    timeout_d = 1'b1;
                end
            end else begin
                // valid low: either idle or a dropped transfer; both end the stall.
                stall_cnt_d = '0;
            end

            if (pending_q && valid[c] && (ch_data != held_q)) begin
                stable_d = 1'b1;
            end

            if (pending_q && !valid[c]) begin
                drop_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pending_q   <= 1'b0;
                held_q      <= '0;
                stall_cnt_q <= '0;
                count_q     <= '0;
                stable_q    <= 1'b0;
                drop_q      <= 1'b0;
                timeout_q   <= 1'b0;
            end else if (clear) begin
                // Clear wins over any event sampled on the same edge.
                pending_q   <= 1'b0;
                held_q      <= '0;
                stall_cnt_q <= '0;
                count_q     <= '0;
                stable_q    <= 1'b0;
                drop_q      <= 1'b0;
                timeout_q   <= 1'b0;
            end else if (en) begin
                pending_q   <= pending_d;
                held_q      <= held_d;
                stall_cnt_q <= stall_cnt_d;
                count_q     <= count_d;
                stable_q    <= stable_d;
                drop_q      <= drop_d;
                timeout_q   <= timeout_d;
            end
        end

        assign xfer_count[c*CNT_W +: CNT_W] = count_q;
        assign err_stable[c]                = stable_q;
        assign err_drop[c]                  = drop_q;
        assign err_timeout[c]               = timeout_q;
    end

    assign irq = |( (err_timeout & {NUM_CH{err_mask[2]}})
                  | (err_drop    & {NUM_CH{err_mask[1]}})
                  | (err_stable  & {NUM_CH{err_mask[0]}}) );

endmodule

// File: tb/tb_stream_protocol_checker.sv
// Purpose : directed self-checking bench for stream_protocol_checker (4-channel
//           instance plus a 1-channel CNT_W=4 instance for counter wrap).
// Latency : inputs change 1 time unit after posedge, outputs checked at the same point.
// Backpressure: ready is driven directly by the stimulus.

module tb_stream_protocol_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        clear;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [31:0] data;
    logic [2:0]  err_mask;
    logic [63:0] xfer_count;
    logic [3:0]  err_stable;
    logic [3:0]  err_drop;
    logic [3:0]  err_timeout;
    logic        irq;

    logic [0:0]  w_valid;
    logic [0:0]  w_ready;
    logic [7:0]  w_data;
    logic [3:0]  w_count;
    logic [0:0]  w_stable;
    logic [0:0]  w_drop;
    logic [0:0]  w_timeout;
    logic        w_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_protocol_checker #(
        .NUM_CH(4), .DATA_W(8), .CNT_W(16), .STALL_MAX(64)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .valid(valid), .ready(ready), .data(data), .err_mask(err_mask),
        .xfer_count(xfer_count), .err_stable(err_stable), .err_drop(err_drop),
        .err_timeout(err_timeout), .irq(irq)
    );

    stream_protocol_checker #(
        .NUM_CH(1), .DATA_W(8), .CNT_W(4), .STALL_MAX(64)
    ) dut_w (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .valid(w_valid), .ready(w_ready), .data(w_data), .err_mask(err_mask),
        .xfer_count(w_count), .err_stable(w_stable), .err_drop(w_drop),
        .err_timeout(w_timeout), .irq(w_irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        clear    = 1'b0;
        valid    = '0;
        ready    = '0;
        data     = '0;
        err_mask = 3'b111;
        w_valid  = '0;
        w_ready  = '0;
        w_data   = '0;

        // Reset state
        tick(3);
        check("rst_count", xfer_count, 64'h0);
        check("rst_flags", {err_timeout, err_drop, err_stable}, 12'h0);
        check("rst_irq", irq, 1'b0);
        reset = 1'b1;
        en    = 1'b1;
        tick(1);

        // ch0: five back-to-back handshakes
        valid[0] = 1'b1;
        ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data[7:0] = 8'h10 + 8'(i);
            tick(1);
        end
        valid[0] = 1'b0;
        ready[0] = 1'b0;
        check("hs5_count", xfer_count, 64'h0000_0000_0000_0005);
        check("hs5_flags", {err_timeout, err_drop, err_stable}, 12'h0);
        check("hs5_irq", irq, 1'b0);

        // ch1: clean 3-cycle stall then handshake
        valid[1]   = 1'b1;
        data[15:8] = 8'hA5;
        tick(3);
        ready[1] = 1'b1;
        tick(1);
        valid[1] = 1'b0;
        ready[1] = 1'b0;
        check("stall_ok_count", xfer_count[31:16], 16'd1);
        check("stall_ok_flags", {err_timeout, err_drop, err_stable}, 12'h0);

        // ch1: payload changes on stall cycle 2
        valid[1]   = 1'b1;
        data[15:8] = 8'hA5;
        tick(1);
        data[15:8] = 8'h5A;
        tick(2);
        ready[1] = 1'b1;
        tick(1);
        valid[1] = 1'b0;
        ready[1] = 1'b0;
        check("unstable_flag", err_stable, 4'b0010);
        check("unstable_count", xfer_count[31:16], 16'd2);
        err_mask = 3'b001;
        #1;
        check("irq_mask_stable", irq, 1'b1);
        err_mask = 3'b000;
        #1;
        check("irq_mask_none", irq, 1'b0);
        err_mask = 3'b110;
        #1;
        check("irq_mask_other", irq, 1'b0);
        err_mask = 3'b111;

        // ch2: stall then valid withdrawn
        valid[2] = 1'b1;
        tick(2);
        check("pre_drop", err_drop, 4'b0000);
        valid[2] = 1'b0;
        tick(1);
        check("drop_flag", err_drop, 4'b0100);
        check("drop_count", xfer_count[47:32], 16'd0);
        err_mask = 3'b010;
        #1;
        check("irq_mask_drop", irq, 1'b1);
        err_mask = 3'b111;

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_all", {xfer_count, err_timeout, err_drop, err_stable}, 76'h0);

        // ch3: timeout at STALL_MAX
        valid[3]    = 1'b1;
        data[31:24] = 8'h77;
        tick(63);
        check("to_63", err_timeout, 4'b0000);
        tick(1);
        check("to_64", err_timeout, 4'b1000);
        ready[3] = 1'b1;
        tick(1);
        valid[3] = 1'b0;
        ready[3] = 1'b0;
        tick(1);
        check("to_hs_count", xfer_count[63:48], 16'd1);
        check("to_sticky", err_timeout, 4'b1000);
        check("to_no_other", {err_drop, err_stable}, 8'h0);
        err_mask = 3'b100;
        #1;
        check("irq_mask_to", irq, 1'b1);
        err_mask = 3'b111;

        // Narrow instance: drop flag, then 17 handshakes wrap a 4-bit counter
        w_valid = 1'b1;
        tick(1);
        w_valid = 1'b0;
        tick(1);
        check("w_drop", w_drop, 1'b1);
        w_valid = 1'b1;
        w_ready = 1'b1;
        tick(17);
        check("w_wrap", w_count, 4'd1);
        clear = 1'b1;
        tick(1);
        clear   = 1'b0;
        w_valid = 1'b0;
        w_ready = 1'b0;
        check("w_clear_count", w_count, 4'd0);
        check("w_clear_flags", {w_timeout, w_drop, w_stable}, 3'b000);
        check("main_cleared", {xfer_count, err_timeout}, 68'h0);

        // en=0 window in the middle of a ch3 stall
        valid[3]    = 1'b1;
        data[31:24] = 8'h33;
        tick(5);
        en = 1'b0;
        valid[0] = 1'b1;
        ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid[3]    = i[0];
            data[31:24] = 8'(i * 7);
            tick(1);
        end
        valid[0]    = 1'b0;
        ready[0]    = 1'b0;
        valid[3]    = 1'b1;
        data[31:24] = 8'h33;
        check("en0_count", xfer_count, 64'h0);
        check("en0_flags", {err_timeout, err_drop, err_stable}, 12'h0);
        en = 1'b1;
        tick(58);
        check("resume_58", err_timeout, 4'b0000);
        tick(1);
        check("resume_59", err_timeout, 4'b1000);
        check("resume_clean", {err_drop, err_stable}, 8'h0);

        // Async reset with live state
        valid[1] = 1'b1;
        ready[1] = 1'b1;
        tick(1);
        valid[1] = 1'b0;
        ready[1] = 1'b0;
        check("pre_rst_count", xfer_count[31:16], 16'd1);
        reset = 1'b0;
        #1;
        check("arst_count", xfer_count, 64'h0);
        check("arst_flags", {err_timeout, err_drop, err_stable}, 12'h0);
        check("arst_irq", irq, 1'b0);
        tick(1);
        reset       = 1'b1;
        data[31:24] = 8'h44;
        tick(63);
        check("post_rst_63", err_timeout, 4'b0000);
        tick(1);
        check("post_rst_64", err_timeout, 4'b1000);
        check("post_rst_stable", err_stable, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
